// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM states and instruction decode constants.
package fetch_unit_pkg;

   localparam int unsigned PC_W_DEF = 10;
   localparam int unsigned IW_DEF   = 9;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } fetch_state_t;

   // {opcode, fcode} patterns, compared with ==? so '?' bits are don't-care
   localparam logic [4:0] cJ    = 5'b1100?;
   localparam logic [4:0] cCALL = 5'b11010;
   localparam logic [4:0] cRET  = 5'b11011;
   localparam logic [4:0] cHALT = 5'b11111;

endpackage

// File: rtl/fetch_unit_return_stack.sv
// Return-address LIFO; the owner sequences push/pop and never issues both at once.
module fetch_unit_return_stack #(
   parameter int unsigned PC_W      = 10,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            clear,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] push_data,
   output logic            full,
   output logic            empty,
   output logic [PC_W-1:0] top
);

   localparam int unsigned PtrW = $clog2(RAS_DEPTH + 1);
   localparam int unsigned IdxW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   logic [PC_W-1:0] mem [RAS_DEPTH];
   logic [PtrW-1:0] ptr_q;
   logic [IdxW-1:0] top_idx;
   logic [IdxW-1:0] wr_idx;

   assign full    = (ptr_q == PtrW'(RAS_DEPTH));
   assign empty   = (ptr_q == '0);
   assign top_idx = IdxW'(ptr_q - 1'b1);
   assign wr_idx  = IdxW'(ptr_q);
   assign top     = mem[top_idx];

   // Stack storage: written only on an accepted push.
   always_ff @(posedge CLK) begin
      if (push && !full) begin
         mem[wr_idx] <= push_data;
      end
   end

   // Occupancy pointer; clear empties the stack when execution restarts.
   always_ff @(posedge CLK) begin
      if (reset || clear) begin
         ptr_q <= '0;
      end else if (push && !full) begin
         ptr_q <= ptr_q + 1'b1;
      end else if (pop && !empty) begin
         ptr_q <= ptr_q - 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: PC sequencing, branch resolution, call/return stack, DONE.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned   PC_W       = PC_W_DEF,
   parameter int unsigned   IW         = IW_DEF,
   parameter int unsigned   RAS_DEPTH  = 4,
   parameter logic [PC_W-1:0] START_ADDR = '0
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            start,
   output logic [PC_W-1:0] instr_addr,
   input  logic [IW-1:0]   instr_data,
   output logic [3:0]      opcode,
   output logic            fcode,
   output logic [3:0]      operand,
   input  logic            CTRL_branch_rel_nz,
   input  logic            CTRL_branch_rel_z,
   input  logic            CTRL_branch_abs,
   input  logic            zero,
   input  logic [7:0]      rel_offset,
   input  logic [PC_W-1:0] abs_target,
   output logic            DONE,
   output logic            ras_err,
   output logic [15:0]     instr_ct
);

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            done_q;
   logic            err_q, err_d;
   logic [15:0]     ct_q, ct_d;

   logic            ras_push, ras_pop, ras_clear;
   logic            ras_full, ras_empty;
   logic [PC_W-1:0] ras_top;

   logic [4:0]      dec;
   logic [PC_W-1:0] pc_inc, pc_rel, rel_ext;
   logic            rel_taken;

   assign opcode  = instr_data[8:5];
   assign fcode   = instr_data[4];
   assign operand = instr_data[3:0];
   assign dec     = {opcode, fcode};

   assign rel_ext   = {{(PC_W - 8){rel_offset[7]}}, rel_offset};
   assign pc_inc    = pc_q + 1'b1;
   assign pc_rel    = pc_q + rel_ext;
   // Both rel controls together make the branch taken for either zero value.
   assign rel_taken = (CTRL_branch_rel_z & zero) | (CTRL_branch_rel_nz & ~zero);

   assign instr_addr = pc_q;
   assign DONE       = done_q;
   assign ras_err    = err_q;
   assign instr_ct   = ct_q;

   fetch_unit_return_stack #(
      .PC_W      (PC_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_return_stack (
      .CLK       (CLK),
      .reset     (reset),
      .clear     (ras_clear),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_inc),
      .full      (ras_full),
      .empty     (ras_empty),
      .top       (ras_top)
   );

   // Next-state, next-PC and stack control.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      err_d     = err_q;
      ct_d      = ct_q;
      ras_push  = 1'b0;
      ras_pop   = 1'b0;
      ras_clear = 1'b0;

      unique case (state_q)
         IDLE, HALT: begin
            if (start) begin
               state_d   = RUN;
               pc_d      = START_ADDR;
               ct_d      = '0;
               err_d     = 1'b0;
               ras_clear = 1'b1;
            end
         end
         RUN: begin
            if (ct_q != 16'hFFFF) begin
               ct_d = ct_q + 16'd1;
            end
            if (dec ==? cHALT) begin
               state_d = HALT;
            end else if (CTRL_branch_abs && (dec ==? cRET)) begin
               if (ras_empty) begin
                  // Unbalanced return: stop where we are.
                  err_d   = 1'b1;
                  state_d = HALT;
               end else begin
                  pc_d    = ras_top;
                  ras_pop = 1'b1;
               end
            end else if (CTRL_branch_abs && (dec ==? cCALL)) begin
               // Overflowing call still jumps; only the return address is lost.
               if (ras_full) begin
                  err_d = 1'b1;
               end else begin
                  ras_push = 1'b1;
               end
               pc_d = abs_target;
            end else if (CTRL_branch_abs) begin
               pc_d = abs_target;
            end else if (rel_taken) begin
               pc_d = pc_rel;
            end else begin
               pc_d = pc_inc;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; DONE is registered from the next state.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= START_ADDR;
         done_q  <= 1'b1;
         err_q   <= 1'b0;
         ct_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         done_q  <= (state_d != RUN);
         err_q   <= err_d;
         ct_q    <= ct_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit.
module tb_fetch_unit;

   typedef struct packed {
      logic [9:0]  pc;
      logic        done;
      logic        err;
      logic [15:0] ct;
      logic [8:0]  instr;
   } exp_t;

   localparam logic [8:0] INSTR_CALL = 9'h1A0;
   localparam logic [8:0] INSTR_RET  = 9'h1B0;
   localparam logic [8:0] INSTR_HALT = 9'h1F0;

   logic        CLK;
   logic        reset;
   logic        start;
   logic [9:0]  instr_addr;
   logic [8:0]  instr_data;
   logic [3:0]  opcode;
   logic        fcode;
   logic [3:0]  operand;
   logic        CTRL_branch_rel_nz;
   logic        CTRL_branch_rel_z;
   logic        CTRL_branch_abs;
   logic        zero;
   logic [7:0]  rel_offset;
   logic [9:0]  abs_target;
   logic        DONE;
   logic        ras_err;
   logic [15:0] instr_ct;

   logic [8:0]  imem [0:1023];
   exp_t        sb_q [$];
   string       nm_q [$];
   int          vectors;
   int          miscompares;

   assign instr_data = imem[instr_addr];

   fetch_unit #(
      .PC_W       (10),
      .IW         (9),
      .RAS_DEPTH  (4),
      .START_ADDR (10'd0)
   ) dut (
      .CLK                (CLK),
      .reset              (reset),
      .start              (start),
      .instr_addr         (instr_addr),
      .instr_data         (instr_data),
      .opcode             (opcode),
      .fcode              (fcode),
      .operand            (operand),
      .CTRL_branch_rel_nz (CTRL_branch_rel_nz),
      .CTRL_branch_rel_z  (CTRL_branch_rel_z),
      .CTRL_branch_abs    (CTRL_branch_abs),
      .zero               (zero),
      .rel_offset         (rel_offset),
      .abs_target         (abs_target),
      .DONE               (DONE),
      .ras_err            (ras_err),
      .instr_ct           (instr_ct)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Drive one cycle of inputs at the falling edge and queue the outputs expected after the
   // following rising edge.
   task automatic step(input string nm, input logic rst, input logic st, input logic ab,
                       input logic rz, input logic rnz, input logic zf, input logic [7:0] off,
                       input logic [9:0] tgt, input logic [9:0] epc, input logic edone,
                       input logic eerr, input logic [15:0] ect);
      exp_t e;
      @(negedge CLK);
      reset              = rst;
      start              = st;
      CTRL_branch_abs    = ab;
      CTRL_branch_rel_z  = rz;
      CTRL_branch_rel_nz = rnz;
      zero               = zf;
      rel_offset         = off;
      abs_target         = tgt;
      e.pc    = epc;
      e.done  = edone;
      e.err   = eerr;
      e.ct    = ect;
      e.instr = imem[epc];
      sb_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   task automatic idle(input string nm, input logic [9:0] epc, input logic edone,
                       input logic eerr, input logic [15:0] ect);
      step(nm, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0, epc, edone, eerr, ect);
   endtask

   task automatic jump(input string nm, input logic [9:0] tgt, input logic eerr,
                       input logic [15:0] ect);
      step(nm, 0, 0, 1, 0, 0, 0, 8'h00, tgt, tgt, 0, eerr, ect);
   endtask

   // Monitor: compares every queued expectation shortly after the rising edge.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(posedge CLK);
         #2;
         if (sb_q.size() != 0) begin
            e  = sb_q.pop_front();
            nm = nm_q.pop_front();
            vectors++;
            if (instr_addr !== e.pc || DONE !== e.done || ras_err !== e.err ||
                instr_ct !== e.ct || {opcode, fcode, operand} !== e.instr) begin
               miscompares++;
               $display("FAIL %s: got pc=%0d done=%b err=%b ct=%0d fields=%h, want pc=%0d done=%b err=%b ct=%0d fields=%h",
                        nm, instr_addr, DONE, ras_err, instr_ct, {opcode, fcode, operand},
                        e.pc, e.done, e.err, e.ct, e.instr);
            end
         end
      end
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      for (int i = 0; i < 1024; i++) imem[i] = 9'h000;
      imem[1]    = 9'h0A5;
      imem[2]    = 9'h15A;
      imem[6]    = 9'h033;
      imem[7]    = INSTR_RET;
      imem[10]   = INSTR_CALL;
      imem[20]   = INSTR_HALT;
      imem[45]   = INSTR_RET;
      imem[50]   = INSTR_CALL;
      imem[60]   = INSTR_CALL;
      imem[70]   = INSTR_CALL;
      imem[80]   = INSTR_CALL;
      imem[90]   = INSTR_CALL;
      imem[200]  = INSTR_RET;
      imem[1023] = 9'h0FF;

      reset = 1'b1; start = 1'b0; CTRL_branch_abs = 1'b0; CTRL_branch_rel_z = 1'b0;
      CTRL_branch_rel_nz = 1'b0; zero = 1'b0; rel_offset = 8'h00; abs_target = 10'd0;

      // Reset and sequential fetch
      step("reset0", 1, 0, 0, 0, 0, 0, 8'h00, 10'd0, 10'd0, 1, 0, 16'd0);
      step("reset1", 1, 0, 0, 0, 0, 0, 8'h00, 10'd0, 10'd0, 1, 0, 16'd0);
      idle("idle_wait", 10'd0, 1, 0, 16'd0);
      step("start", 0, 1, 0, 0, 0, 0, 8'h00, 10'd0, 10'd0, 0, 0, 16'd0);
      idle("seq1", 10'd1, 0, 0, 16'd1);
      idle("seq2", 10'd2, 0, 0, 16'd2);
      idle("seq3", 10'd3, 0, 0, 16'd3);

      // Relative branches
      jump("jmp5", 10'd5, 0, 16'd4);
      step("beqz_taken", 0, 0, 0, 1, 0, 1, 8'hFD, 10'd0, 10'd2, 0, 0, 16'd5);
      jump("jmp5b", 10'd5, 0, 16'd6);
      step("beqz_nt", 0, 0, 0, 1, 0, 0, 8'hFD, 10'd0, 10'd6, 0, 0, 16'd7);
      jump("jmp5c", 10'd5, 0, 16'd8);
      step("bneqz_taken", 0, 0, 0, 0, 1, 0, 8'h04, 10'd0, 10'd9, 0, 0, 16'd9);
      step("both_rel_z1", 0, 0, 0, 1, 1, 1, 8'h01, 10'd0, 10'd10, 0, 0, 16'd10);

      // Call / return
      step("call10", 0, 0, 1, 0, 0, 0, 8'h00, 10'd40, 10'd40, 0, 0, 16'd11);
      step("bneqz_nt", 0, 0, 0, 0, 1, 1, 8'h04, 10'd0, 10'd41, 0, 0, 16'd12);
      step("both_rel_z0", 0, 0, 0, 1, 1, 0, 8'h04, 10'd0, 10'd45, 0, 0, 16'd13);
      jump("ret45", 10'd11, 0, 16'd14);
      jump("jmp50", 10'd50, 0, 16'd15);
      jump("call_n1", 10'd60, 0, 16'd16);
      jump("call_n2", 10'd70, 0, 16'd17);
      jump("call_n3", 10'd80, 0, 16'd18);
      jump("call_n4", 10'd90, 0, 16'd19);
      jump("call_n5_full", 10'd200, 1, 16'd20);
      step("ret_after_ovf", 0, 0, 1, 0, 0, 0, 8'h00, 10'd999, 10'd81, 0, 1, 16'd21);

      // Halt, hold, restart
      jump("jmp20", 10'd20, 1, 16'd22);
      idle("halt20", 10'd20, 1, 1, 16'd23);
      for (int i = 0; i < 10; i++) begin
         step("halt_hold", 0, 0, i[0], i[1], i[2], 0, 8'h05, 10'd99, 10'd20, 1, 1, 16'd23);
      end
      step("restart", 0, 1, 0, 0, 0, 0, 8'h00, 10'd0, 10'd0, 0, 0, 16'd0);

      // Return with empty stack
      jump("jmp7", 10'd7, 0, 16'd1);
      step("ret_empty", 0, 0, 1, 0, 0, 0, 8'h00, 10'd300, 10'd7, 1, 1, 16'd2);
      idle("ret_empty_hold", 10'd7, 1, 1, 16'd2);
      step("restart2", 0, 1, 0, 0, 0, 0, 8'h00, 10'd0, 10'd0, 0, 0, 16'd0);
      step("run_ign_start", 0, 1, 0, 0, 0, 0, 8'h00, 10'd0, 10'd1, 0, 0, 16'd1);

      // Wrap-around
      jump("jmp1023", 10'd1023, 0, 16'd2);
      idle("wrap_inc", 10'd0, 0, 0, 16'd3);
      step("wrap_rel", 0, 0, 0, 1, 0, 1, 8'hFF, 10'd0, 10'd1023, 0, 0, 16'd4);
      jump("jmp100", 10'd100, 0, 16'd5);

      // Reset mid-run and reset over start
      step("reset_mid", 1, 0, 0, 0, 0, 0, 8'h00, 10'd0, 10'd0, 1, 0, 16'd0);
      step("reset_start", 1, 1, 0, 0, 0, 0, 8'h00, 10'd0, 10'd0, 1, 0, 16'd0);
      idle("still_idle", 10'd0, 1, 0, 16'd0);

      @(negedge CLK);
      reset = 1'b0; start = 1'b0; CTRL_branch_abs = 1'b0;
      for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge CLK);
      #4;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch / program-counter stage directly upstream of the control path.
- Holds the PC and addresses the instruction memory.
- Splits each fetched instruction into opcode/fcode/operand for decode and the datapath.
- Resolves branch controls coming back from the control path, keeps a small return-address stack for CALL/RET, and generates DONE, which gates all control outputs.

Parameters:
- PC_W, 10, program counter / instruction address width.
- IW, 9, instruction width; opcode = instr[8:5], fcode = instr[4], operand = instr[3:0].
- RAS_DEPTH, 4, return-address stack entries.
- START_ADDR, 0, PC loaded on start.

Ports:
- CLK  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins execution from START_ADDR.
- instr_addr  out  PC_W  current PC, drives instruction memory (combinational read).
- instr_data  in  IW  instruction at instr_addr.
- opcode  out  4  instr_data[8:5].
- fcode  out  1  instr_data[4].
- operand  out  4  instr_data[3:0].
- CTRL_branch_rel_nz  in  1  from control path.
- CTRL_branch_rel_z  in  1  from control path.
- CTRL_branch_abs  in  1  from control path.
- zero  in  1  ALU/register zero flag for the current instruction.
- rel_offset  in  8  signed relative branch offset from datapath.
- abs_target  in  PC_W  absolute jump/call target from datapath.
- DONE  out  1  high when not executing.
- ras_err  out  1  sticky: push on full or pop on empty.
- instr_ct  out  16  instructions retired since start, saturating.

Behaviour:
- Reset values: state=IDLE, PC=START_ADDR, DONE=1, ras_err=0, instr_ct=0, RAS pointer=0.
- States: IDLE, RUN, HALT. DONE=1 in IDLE and HALT, 0 in RUN. DONE is registered.
- Transitions:
  - IDLE/HALT + start → RUN: PC←START_ADDR, instr_ct←0, RAS pointer←0, ras_err←0.
  - RUN ignores start.
  - RUN + fetched {opcode,fcode} matches cHALT → HALT next cycle. PC freezes at the halt address; instr_ct counts the halt instruction.
- opcode/fcode/operand are purely combinational slices of instr_data in every state.
- Next-PC in RUN (one instruction per cycle, zero added latency), priority highest first:
  1. CTRL_branch_abs with cRET: PC←RAS top, pop.
  2. CTRL_branch_abs with cCALL: push PC+1, PC←abs_target.
  3. CTRL_branch_abs otherwise (cJ): PC←abs_target.
  4. CTRL_branch_rel_z & zero, or CTRL_branch_rel_nz & ~zero: PC←PC + sign-extended rel_offset.
  5. Otherwise PC←PC+1.
- Arithmetic is modulo 2^PC_W: wrap-around is legal, no flag. A relative branch that is not taken falls through to PC+1.
- CALL with RAS full: push suppressed, jump still taken, ras_err←1.
- RET with RAS empty: ras_err←1, state→HALT, PC unchanged.
- If both rel controls are asserted together, the taken condition is satisfied for either zero value. This is legal and exercised.
- instr_ct increments every RUN cycle and saturates at 16'hFFFF.
- reset mid-RUN: full return to reset values next edge; reset has priority over start.
- Outside RUN, branch inputs are ignored (the control path also drives them 0 while DONE=1).

Decomposition:
- Shared definitions package gains:
  - cHALT, PC_W default, and state typedef fetch_state_t {IDLE, RUN, HALT}.
  - Reuse the existing cJ/cCALL/cRET casez constants for decode.
- One sub-module, return_stack: RAS_DEPTH×PC_W LIFO with push, pop, full, empty, top. It sits under fetch_unit; all sequencing stays in fetch_unit.

Test Plan:
- Reset then start: PC=0 → DONE falls the cycle after start; instr_addr steps 0,1,2,3…; instr_ct=3 after 3 RUN cycles.
- BEQZ at PC=5 with zero=1, rel_offset=-3 → next PC=2. Same with zero=0 → PC=6. BNEQZ with zero=0, offset +4 → PC=9.
- CALL at PC=10, abs_target=40 → PC=40. RET at 45 → PC=11. Five nested CALLs with RAS_DEPTH=4 → ras_err=1 on the 5th, jump still taken.
- RET with empty stack at PC=7 → ras_err=1, DONE=1 next cycle, instr_addr stays 7.
- HALT at PC=20 → DONE=1 next cycle, PC held at 20 for 10 cycles. start → PC=0, instr_ct=0, DONE=0.
- Wrap-around and reset: PC=1023 non-branch → PC=0. Assert reset mid-RUN at PC=100 → next edge PC=0, DONE=1, state IDLE. start coincident with reset → stays IDLE.
